// File: rtl/spectral_peak_fsm_pkg.sv
// spectral_peak_fsm_pkg: shared state encoding, magnitude-mode selectors and complex sample type.
package spectral_peak_fsm_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FETCH, S_PRESENT} state_t;
  localparam int MAG_MAX_MIN = 0;
  localparam int MAG_L1 = 1;
  localparam int CPLX_W = 18;
  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/spectral_peak_fsm_mag.sv
// cplx_mag_approx: combinational approximate magnitude of a signed complex sample.
module cplx_mag_approx
  import spectral_peak_fsm_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int MAG_MODE = MAG_MAX_MIN
) (
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  output logic [DATA_W:0]   o_mag
);
  logic [DATA_W-1:0] w_a, w_b, w_max, w_min;
  // Unsigned DATA_W-bit abs keeps the most negative value exact.
  always_comb begin
    w_a = i_re[DATA_W-1] ? ~i_re + 1'b1 : i_re;
    w_b = i_im[DATA_W-1] ? ~i_im + 1'b1 : i_im;
    w_max = (w_a > w_b) ? w_a : w_b;
    w_min = (w_a > w_b) ? w_b : w_a;
    o_mag = (MAG_MODE == MAG_L1) ? {1'b0, w_a} + {1'b0, w_b}
                                 : {1'b0, w_max} + {2'b0, w_min[DATA_W-1:1]};
  end
endmodule

// File: rtl/spectral_peak_fsm.sv
// spectral_peak_fsm: captures an FFT frame, tracks the windowed magnitude peak and
// presents it with its neighbours; serves the stored frame for readback between frames.
module spectral_peak_fsm
  import spectral_peak_fsm_pkg::*;
#(
  parameter int N_BINS = 512,
  parameter int ADDR_W = $clog2(N_BINS),
  parameter int DATA_W = 18,
  parameter int MAG_MODE = MAG_MAX_MIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_done,
  input  logic [ADDR_W-1:0]     fft_address,
  input  logic                  fft_valid,
  input  logic [2*DATA_W-1:0]   fft_data,
  input  logic [ADDR_W-1:0]     bin_lo,
  input  logic [ADDR_W-1:0]     bin_hi,
  output logic                  peak_valid,
  input  logic                  peak_ready,
  output logic                  peak_found,
  output logic [ADDR_W-1:0]     peak_index,
  output logic [DATA_W-1:0]     peak_re,
  output logic [DATA_W-1:0]     peak_im,
  output logic [DATA_W:0]       peak_mag,
  output logic [DATA_W:0]       left_mag,
  output logic [DATA_W:0]       right_mag,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  rd_valid
);
  localparam int MAG_W = DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);

  state_t r_state, w_next;
  logic [1:0] r_fcnt;
  logic [ADDR_W-1:0] r_lo, r_hi, r_best_idx, w_faddr, w_maddr;
  logic [MAG_W-1:0] r_best_mag, r_left, r_mid, r_mq, w_mag;
  logic [2*DATA_W-1:0] r_mid_data, r_fq, r_rd_hold;
  logic [2*DATA_W-1:0] r_frame [N_BINS];
  logic [MAG_W-1:0] r_mag_ram [N_BINS];
  logic r_found, w_we, w_take, w_last, w_fetch, w_start;

  cplx_mag_approx #(.DATA_W(DATA_W), .MAG_MODE(MAG_MODE)) u_mag (
    .i_re (fft_data[2*DATA_W-1:DATA_W]),
    .i_im (fft_data[DATA_W-1:0]),
    .o_mag(w_mag)
  );

  // A frame start in CAPTURE wins over any sample or end-of-frame in the same cycle.
  assign w_fetch = (r_state == S_FETCH);
  assign w_start = fft_done && (r_state == S_IDLE || r_state == S_CAPTURE);
  assign w_we = (r_state == S_CAPTURE) && fft_valid;
  assign w_take = w_we && !fft_done && fft_address >= r_lo && fft_address <= r_hi &&
                  (!r_found || w_mag > r_best_mag);
  assign w_last = w_we && !fft_done && fft_address == LAST;
  assign w_maddr = !w_fetch ? fft_address : (r_fcnt == 2'd0) ? r_best_idx - 1'b1 :
                   (r_fcnt == 2'd1) ? r_best_idx : r_best_idx + 1'b1;
  assign w_faddr = w_fetch ? r_best_idx : (r_state == S_CAPTURE) ? fft_address : rd_addr;
  assign rd_data = rd_valid ? r_fq : r_rd_hold;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    busy = (r_state == S_CAPTURE) || w_fetch;
    peak_valid = (r_state == S_PRESENT);
    case (r_state)
      S_IDLE:    w_next = fft_done ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_next = fft_done ? S_CAPTURE : w_last ? S_FETCH : S_CAPTURE;
      S_FETCH:   w_next = (r_fcnt == 2'd3) ? S_PRESENT : S_FETCH;
      default:   w_next = peak_ready ? S_IDLE : S_PRESENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_frame[fft_address] <= fft_data;
      r_mag_ram[fft_address] <= w_mag;
    end
    r_fq <= r_frame[w_faddr];
    r_mq <= r_mag_ram[w_maddr];
  end

  // FETCH reads idx-1, idx, idx+1 on counts 0..2; each result lands one count later.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fcnt <= '0;
      r_lo <= '0;
      r_hi <= '0;
      r_best_idx <= '0;
      r_best_mag <= '0;
      r_found <= 1'b0;
      r_left <= '0;
      r_mid <= '0;
      r_mid_data <= '0;
      r_rd_hold <= '0;
      rd_valid <= 1'b0;
      overrun <= 1'b0;
      peak_found <= 1'b0;
      peak_index <= '0;
      peak_re <= '0;
      peak_im <= '0;
      peak_mag <= '0;
      left_mag <= '0;
      right_mag <= '0;
    end else begin
      overrun <= fft_done && r_state != S_IDLE;
      rd_valid <= rd_en && (r_state == S_IDLE || r_state == S_PRESENT);
      r_rd_hold <= rd_data;
      r_fcnt <= w_fetch ? r_fcnt + 2'd1 : 2'd0;
      if (w_start) begin
        r_lo <= bin_lo;
        r_hi <= bin_hi;
        r_best_idx <= bin_lo;
        r_best_mag <= '0;
        r_found <= 1'b0;
      end else if (w_take) begin
        r_best_idx <= fft_address;
        r_best_mag <= w_mag;
        r_found <= 1'b1;
      end
      if (w_fetch && r_fcnt == 2'd1) r_left <= (r_best_idx == '0) ? '0 : r_mq;
      if (w_fetch && r_fcnt == 2'd2) begin
        r_mid <= r_mq;
        r_mid_data <= r_fq;
      end
      if (w_fetch && r_fcnt == 2'd3) begin
        peak_found <= r_found;
        peak_index <= r_best_idx;
        {peak_re, peak_im} <= r_mid_data;
        peak_mag <= r_mid;
        left_mag <= r_left;
        right_mag <= (r_best_idx == LAST) ? '0 : r_mq;
      end
    end
endmodule

// File: tb/tb_spectral_peak_fsm.sv
// tb_spectral_peak_fsm: directed and randomized frames against an array-based peak model.
module tb_spectral_peak_fsm;
  import spectral_peak_fsm_pkg::*;
  localparam int N = 512;
  localparam int AW = 9;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fft_done = 1'b0, fft_valid = 1'b0, peak_ready = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] fft_address = '0, bin_lo = '0, bin_hi = '0, rd_addr = '0;
  logic [2*DW-1:0] fft_data = '0;
  logic a_valid, a_found, a_busy, a_ovr, a_rdv, b_valid, b_found, b_busy, b_ovr, b_rdv;
  logic [AW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [DW:0] a_mag, a_left, a_right, b_mag, b_left, b_right;
  logic [2*DW-1:0] a_rdd, b_rdd;

  int tests = 0, fails = 0;
  int m_re[N], m_im[N];

  always #5 clk = ~clk;

  spectral_peak_fsm #(.N_BINS(N), .DATA_W(DW), .MAG_MODE(MAG_MAX_MIN)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done), .fft_address(fft_address),
    .fft_valid(fft_valid), .fft_data(fft_data), .bin_lo(bin_lo), .bin_hi(bin_hi),
    .peak_valid(a_valid), .peak_ready(peak_ready), .peak_found(a_found),
    .peak_index(a_idx), .peak_re(a_re), .peak_im(a_im), .peak_mag(a_mag),
    .left_mag(a_left), .right_mag(a_right), .busy(a_busy), .overrun(a_ovr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rdd), .rd_valid(a_rdv));

  spectral_peak_fsm #(.N_BINS(N), .DATA_W(DW), .MAG_MODE(MAG_L1)) dut_l1 (
    .clk(clk), .rst(rst), .fft_done(fft_done), .fft_address(fft_address),
    .fft_valid(fft_valid), .fft_data(fft_data), .bin_lo(bin_lo), .bin_hi(bin_hi),
    .peak_valid(b_valid), .peak_ready(peak_ready), .peak_found(b_found),
    .peak_index(b_idx), .peak_re(b_re), .peak_im(b_im), .peak_mag(b_mag),
    .left_mag(b_left), .right_mag(b_right), .busy(b_busy), .overrun(b_ovr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rdd), .rd_valid(b_rdv));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] s18(input int v);
    return v[DW-1:0];
  endfunction

  function automatic int amag(input int re, input int im, input int mode);
    int a, b, hi, lo;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    return (mode == MAG_L1) ? a + b : hi + lo / 2;
  endfunction

  // Reference: scan bins in arrival order, strict '>' keeps the earliest of equal peaks.
  task automatic model(input int lo, input int hi, input int mode,
                       output int idx, output int found, output int pm,
                       output int lm, output int rm);
    int best = 0;
    idx = lo;
    found = 0;
    for (int i = 0; i < N; i++)
      if (i >= lo && i <= hi && (found == 0 || amag(m_re[i], m_im[i], mode) > best)) begin
        best = amag(m_re[i], m_im[i], mode);
        idx = i;
        found = 1;
      end
    pm = amag(m_re[idx], m_im[idx], mode);
    lm = (idx == 0) ? 0 : amag(m_re[idx-1], m_im[idx-1], mode);
    rm = (idx == N - 1) ? 0 : amag(m_re[idx+1], m_im[idx+1], mode);
  endtask

  task automatic fill(input int amp);
    for (int i = 0; i < N; i++) begin
      m_re[i] = int'($urandom_range(0, 2 * amp)) - amp;
      m_im[i] = int'($urandom_range(0, 2 * amp)) - amp;
    end
  endtask

  task automatic capture(input int lo, input int hi, input int n, input logic ovr_exp);
    bin_lo = AW'(lo);
    bin_hi = AW'(hi);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("busy_capture", 64'(a_busy), 64'(1));
    chk("overrun_start", 64'(a_ovr), 64'(ovr_exp));
    for (int a = 0; a < n; a++) begin
      fft_valid = 1'b1;
      fft_address = AW'(a);
      fft_data = {s18(m_re[a]), s18(m_im[a])};
      rd_en = (a == 10);
      rd_addr = AW'(37);
      tick();
      if (a == 10) chk("rd_valid_capture", 64'(a_rdv), 64'(0));
    end
    fft_valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic finish_frame(input int lo, input int hi, input bit stall);
    int ei, ef, ep, el, er, bi, bf, bp, bl, br, novr;
    model(lo, hi, MAG_MAX_MIN, ei, ef, ep, el, er);
    model(lo, hi, MAG_L1, bi, bf, bp, bl, br);
    chk("busy_fetch", 64'(a_busy), 64'(1));
    tick();
    tick();
    tick();
    chk("valid_t4", 64'(a_valid), 64'(0));
    tick();
    chk("valid_t5", 64'(a_valid), 64'(1));
    chk("busy_present", 64'(a_busy), 64'(0));
    chk("found", 64'(a_found), 64'(ef));
    chk("index", 64'(a_idx), 64'(ei));
    chk("re", 64'(a_re), 64'(s18(m_re[ei])));
    chk("im", 64'(a_im), 64'(s18(m_im[ei])));
    chk("mag", 64'(a_mag), 64'(ep));
    chk("left", 64'(a_left), 64'(el));
    chk("right", 64'(a_right), 64'(er));
    chk("l1_index", 64'(b_idx), 64'(bi));
    chk("l1_mag", 64'(b_mag), 64'(bp));
    chk("l1_left", 64'(b_left), 64'(bl));
    if (stall) begin
      novr = 0;
      for (int c = 0; c < 20; c++) begin
        fft_done = (c == 5);
        tick();
        fft_done = 1'b0;
        novr += int'(a_ovr);
        chk("stall_valid", 64'(a_valid), 64'(1));
        chk("stall_index", 64'(a_idx), 64'(ei));
        chk("stall_mag", 64'(a_mag), 64'(ep));
      end
      chk("stall_overrun_count", 64'(novr), 64'(1));
    end
    peak_ready = 1'b1;
    tick();
    peak_ready = 1'b0;
    chk("valid_after_hs", 64'(a_valid), 64'(0));
    chk("busy_after_hs", 64'(a_busy), 64'(0));
    chk("index_retained", 64'(a_idx), 64'(ei));
  endtask

  initial begin
    int lo, hi;
    tick();
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_index", 64'(a_idx), 64'(0));
    chk("rst_rd", 64'({a_rdv, a_rdd}), 64'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(a_valid), 64'(0));
    chk("post_rst_overrun", 64'(a_ovr), 64'(0));
    // Basic frame
    for (int i = 0; i < N; i++) begin
      m_re[i] = 10;
      m_im[i] = 10;
    end
    m_re[37] = 3000;
    m_im[37] = -4000;
    capture(0, N - 1, N, 1'b0);
    finish_frame(0, N - 1, 1'b0);
    rd_en = 1'b1;
    rd_addr = AW'(37);
    tick();
    rd_en = 1'b0;
    chk("rd_valid_idle", 64'(a_rdv), 64'(1));
    chk("rd_data_idle", 64'(a_rdd), 64'({s18(3000), s18(-4000)}));
    tick();
    chk("rd_valid_drop", 64'(a_rdv), 64'(0));
    chk("rd_data_hold", 64'(a_rdd), 64'({s18(3000), s18(-4000)}));
    // Window and ties
    fill(1000);
    m_re[50] = 5000; m_im[50] = 0;
    m_re[120] = 5000; m_im[120] = 0;
    m_re[180] = 5000; m_im[180] = 0;
    capture(100, 200, N, 1'b0);
    finish_frame(100, 200, 1'b0);
    // Edge bins
    fill(1000);
    m_re[0] = 20000;
    capture(0, N - 1, N, 1'b0);
    finish_frame(0, N - 1, 1'b0);
    fill(1000);
    m_im[N-1] = -20000;
    capture(0, N - 1, N, 1'b0);
    finish_frame(0, N - 1, 1'b0);
    // Extreme values, stalled handshake with a dropped frame start
    fill(1000);
    m_re[300] = -131072;
    m_im[300] = -131072;
    capture(0, N - 1, N, 1'b0);
    finish_frame(0, N - 1, 1'b1);
    chk("l1_extreme_mag", 64'(b_mag), 64'(262144));
    // Empty window
    fill(5000);
    capture(300, 200, N, 1'b0);
    finish_frame(300, 200, 1'b0);
    // Restart mid-capture at address 200
    fill(50000);
    capture(0, N - 1, 200, 1'b0);
    fill(2000);
    m_re[400] = 9000;
    capture(0, N - 1, N, 1'b1);
    finish_frame(0, N - 1, 1'b0);
    // Random full-range frames and windows
    for (int f = 0; f < 3; f++) begin
      fill(131071);
      lo = int'($urandom_range(0, N - 1));
      hi = int'($urandom_range(lo, N - 1));
      capture(lo, hi, N, 1'b0);
      finish_frame(lo, hi, 1'b0);
    end
    // Asynchronous reset mid-FETCH
    fill(3000);
    capture(0, N - 1, N, 1'b0);
    chk("busy_before_arst", 64'(a_busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(a_valid), 64'(0));
    chk("arst_busy", 64'(a_busy), 64'(0));
    chk("arst_index", 64'(a_idx), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", 64'({a_valid, a_busy}), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
